// File: rtl/lsu_arbiter.sv
// Two-master arbiter in front of a single load/store unit.
// One transaction in flight at a time: IDLE -> ACCESS (-> RESP for loads) -> IDLE.
module lsu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,

  input  logic        i_m0_req,
  input  logic        i_m0_wren,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [3:0]  i_m0_load_type,
  input  logic        i_m0_load_signed,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rdata,

  input  logic        i_m1_req,
  input  logic        i_m1_wren,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic [3:0]  i_m1_load_type,
  input  logic        i_m1_load_signed,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rdata,

  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_lsu_st_data,
  output logic        o_lsu_wren,
  output logic [3:0]  o_lsu_load_type,
  output logic        o_lsu_load_signed,
  input  logic [31:0] i_lsu_ld_data,

  output logic        o_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  logic        rr_last;   // 1: m1 was granted most recently
  logic        owner;     // 0: m0, 1: m1

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        wren_q;
  logic [3:0]  type_q;
  logic        signed_q;

  logic        lsu_wren_q;
  logic        busy_q;
  logic        rvalid0_q;
  logic        rvalid1_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  logic        win;
  logic        gnt_any;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_wren;
  logic [3:0]  sel_type;
  logic        sel_signed;

  always_comb begin
    win = 1'b0;
    if (RR_EN) begin
      if (i_m0_req && i_m1_req)
        win = ~rr_last;
      else
        win = i_m1_req;
    end else begin
      win = ~i_m0_req & i_m1_req;
    end
    gnt_any = (state == IDLE) && i_reset && (i_m0_req || i_m1_req);
  end

  always_comb begin
    sel_addr   = i_m0_addr;
    sel_wdata  = i_m0_wdata;
    sel_wren   = i_m0_wren;
    sel_type   = i_m0_load_type;
    sel_signed = i_m0_load_signed;
    if (win) begin
      sel_addr   = i_m1_addr;
      sel_wdata  = i_m1_wdata;
      sel_wren   = i_m1_wren;
      sel_type   = i_m1_load_type;
      sel_signed = i_m1_load_signed;
    end
  end

  assign o_m0_gnt = gnt_any && !win;
  assign o_m1_gnt = gnt_any &&  win;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state      <= IDLE;
      rr_last    <= 1'b1;
      owner      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wren_q     <= 1'b0;
      type_q     <= '0;
      signed_q   <= 1'b0;
      lsu_wren_q <= 1'b0;
      busy_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            wren_q     <= sel_wren;
            type_q     <= sel_type;
            signed_q   <= sel_signed;
            owner      <= win;
            rr_last    <= win;
            lsu_wren_q <= sel_wren;
            busy_q     <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          lsu_wren_q <= 1'b0;
          if (wren_q) begin
            if (owner) rvalid1_q <= 1'b1;
            else       rvalid0_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            state <= RESP;
          end
        end
        RESP: begin
          if (owner) begin
            rdata1_q  <= i_lsu_ld_data;
            rvalid1_q <= 1'b1;
          end else begin
            rdata0_q  <= i_lsu_ld_data;
            rvalid0_q <= 1'b1;
          end
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          lsu_wren_q <= 1'b0;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign o_lsu_addr        = addr_q;
  assign o_lsu_st_data     = wdata_q;
  assign o_lsu_wren        = lsu_wren_q;
  assign o_lsu_load_type   = type_q;
  assign o_lsu_load_signed = signed_q;
  assign o_busy            = busy_q;
  assign o_m0_rvalid       = rvalid0_q;
  assign o_m1_rvalid       = rvalid1_q;
  assign o_m0_rdata        = rdata0_q;
  assign o_m1_rdata        = rdata1_q;

endmodule
